// File: rtl/vram_arbiter_if.sv
// Writer-side handshake bundle for the VRAM arbiter: two write ports with ack/err return.
interface vram_arbiter_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 15
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [1:0]        ack;
  logic              err;

  // Pixel writers drive requests and observe acks
  modport master (
    output req, addr0, addr1, data0, data1,
    input  ack, err
  );

  // Arbiter consumes requests and returns acks
  modport slave (
    input  req, addr0, addr1, data0, data1,
    output ack, err
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority, two writers share
// the remaining slots round-robin. All memory-side and pixel outputs are registered.
module vram_arbiter #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned FB_W     = 160,
  parameter int unsigned FB_H     = 120,
  parameter int unsigned SCALE_SH = 2
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  vram_arbiter_if.slave     wr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  // One extra bit so a framebuffer filling the whole address space still compares correctly
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0] FB_DEPTH = CMP_W'(FB_W * FB_H);

  logic              ptr;
  logic              ptr_nxt;
  logic [1:0]        ack_q;
  logic [1:0]        ack_nxt;
  logic              err_q;
  logic              err_nxt;
  logic              en_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  logic              disp_c;
  logic [ADDR_W-1:0] row_c;
  logic [ADDR_W-1:0] col_c;
  logic [ADDR_W-1:0] disp_addr_c;
  logic [1:0]        elig_c;
  logic              gnt_c;
  logic [ADDR_W-1:0] gnt_addr_c;
  logic [DATA_W-1:0] gnt_data_c;

  logic              s1_valid;
  logic              s1_on;
  logic              s2_valid;
  logic              s2_on;

  // Display fetch address: screen position scaled down to framebuffer coordinates
  assign disp_c      = p_tick & video_on;
  assign row_c       = ADDR_W'(y >> SCALE_SH);
  assign col_c       = ADDR_W'(x >> SCALE_SH);
  assign disp_addr_c = (row_c * ADDR_W'(FB_W)) + col_c;

  assign wr.ack = ack_q;
  assign wr.err = err_q;

  // Slot decision: display read, else round-robin write (port just acked is masked), else idle
  always_comb begin
    en_nxt     = 1'b0;
    we_nxt     = 1'b0;
    addr_nxt   = mem_addr;
    wdata_nxt  = mem_wdata;
    ack_nxt    = 2'b00;
    err_nxt    = 1'b0;
    ptr_nxt    = ptr;
    elig_c     = wr.req & ~ack_q;
    gnt_c      = elig_c[ptr] ? ptr : ~ptr;
    gnt_addr_c = gnt_c ? wr.addr1 : wr.addr0;
    gnt_data_c = gnt_c ? wr.data1 : wr.data0;
    if (disp_c) begin
      en_nxt   = 1'b1;
      addr_nxt = disp_addr_c;
    end else if (|elig_c) begin
      ack_nxt[gnt_c] = 1'b1;
      ptr_nxt        = ~gnt_c;
      if ({1'b0, gnt_addr_c} >= FB_DEPTH) begin
        err_nxt = 1'b1;
      end else begin
        en_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = gnt_addr_c;
        wdata_nxt = gnt_data_c;
      end
    end
  end

  // Memory port, handshake and round-robin pointer registers
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack_q     <= 2'b00;
      err_q     <= 1'b0;
      ptr       <= 1'b0;
    end else begin
      mem_en    <= en_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      ack_q     <= ack_nxt;
      err_q     <= err_nxt;
      ptr       <= ptr_nxt;
    end
  end

  // Fixed 3-clk pixel pipeline: tick -> read -> rdata -> pix_data (blank ticks yield 0)
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_on     <= 1'b0;
      s2_valid  <= 1'b0;
      s2_on     <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      s1_valid  <= p_tick;
      s1_on     <= disp_c;
      s2_valid  <= s1_valid;
      s2_on     <= s1_on;
      pix_valid <= s2_valid;
      if (s2_valid) begin
        pix_data <= s2_on ? mem_rdata : '0;
      end
    end
  end

endmodule
